fir_mac_seq: RTL and testbench
==============================

Name: fir_mac_seq

Overview:
Parametrised, time-multiplexed FIR filter built around a single signed MAC. It succeeds the fixed 8-bit / 12-coefficient MAC filter and adds the following:
- runtime-writable coefficients
- valid/ready streaming on both sides
- configurable output scaling
- selectable saturate/wrap output mode
It sits between the sample source and the AXI4-Lite register block; coefficients are loaded through the register block.

Parameters:
DATA_WIDTH, 8, signed input sample and coefficient width
NOF_COEFF, 12, number of taps (>=2)
OUT_WIDTH, 20, signed output width
SHIFT, 0, arithmetic right shift applied to accumulator before output narrowing
ACC_WIDTH, 2*DATA_WIDTH+$clog2(NOF_COEFF), accumulator width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of delay line and FSM; coefficients kept
sat_en  in  1  1 = saturate output, 0 = wrap (two's-complement truncation)
coeff_we  in  1  coefficient write strobe
coeff_addr  in  $clog2(NOF_COEFF)  tap index
coeff_data  in  DATA_WIDTH  signed coefficient
coeff_wr_err  out  1  one-cycle pulse: write dropped
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_WIDTH  signed sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_WIDTH  signed filtered sample
out_sat  out  1  result was clipped or wrapped; qualified by out_valid

Behaviour:
- Reset (rst_n=0, async): all outputs are 0. Delay line, coefficient file, accumulator and tap counter are 0. FSM goes to IDLE.
- FSM states IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, x[0]<=in_data, x[k]<=x[k-1], tap counter <=0, go to MAC.
  - MAC: exactly NOF_COEFF cycles. Each cycle: acc += x[i]*h[i], i = 0..NOF_COEFF-1, using full-width signed product and ACC_WIDTH accumulate. acc is cleared at entry. After the last tap, go to OUT.
  - OUT: out_valid=1; out_data/out_sat are registered and held stable until out_valid&out_ready, then go to IDLE.
- Latency: first out_valid is high in cycle T+NOF_COEFF+1 (13 for default). Max throughput is one sample per NOF_COEFF+2 cycles. in_ready=0 in MAC and OUT.
- Output arithmetic: s = acc >>> SHIFT (floor).
  - If s fits in OUT_WIDTH signed: out_data=s, out_sat=0.
  - Else if sat_en=1: clip to max/min, out_sat=1.
  - Else (sat_en=0): out_data = low OUT_WIDTH bits, out_sat=1.
  - sat_en is sampled on the MAC->OUT transition.
- Coefficient writes:
  - Accepted only in IDLE with coeff_addr<NOF_COEFF.
  - Otherwise the write is dropped and coeff_wr_err pulses for one cycle, the cycle after the strobe.
  - A write coincident with sample acceptance in IDLE takes effect and is used by that sample's MAC pass.
- clear (sync, highest priority after reset): zero the delay line and acc, drop out_valid, go to IDLE, next cycle. A result pending in OUT is discarded. Coefficients are unchanged.
- Reset asserted mid-MAC or mid-OUT: immediate return to reset state; no partial result is emitted.
- in_valid while in_ready=0: no state change; the sample must be held by the source (standard valid/ready).

Test Plan:
1. Impulse. Defaults, SHIFT=0, h[k]=k+1. Input 1 then 11 zeros -> outputs 1,2,...,12 in order. First out_valid exactly 13 cycles after acceptance. out_sat=0.
2. Saturation. OUT_WIDTH=16, all h=-128, twelve inputs of -128 -> 12th output acc=196608.
   - sat_en=1: out_data=32767, out_sat=1.
   - Repeat with sat_en=0: out_data=0, out_sat=1.
3. Backpressure. Hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0, a presented sample is not accepted. It is accepted in the first IDLE cycle after the handshake.
4. Coefficient write rules.
   - coeff_we during MAC -> coeff_wr_err pulse, h unchanged.
   - coeff_addr=12 in IDLE -> coeff_wr_err pulse.
   - Write h[0]=5 in the same cycle as accepting sample 3 -> out_data=15 (other h=0).
5. Reset/clear mid-operation.
   - rst_n low during MAC cycle 6 -> all outputs 0 immediately; next sample on an all-zero delay line yields 0.
   - clear in OUT -> out_valid=0 next cycle, coefficients retained (impulse test repeats correctly).
6. SHIFT. SHIFT=2, h[0]=1, input -7 -> out_data=-2 (floor).

Source files
------------

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter built around one signed multiply-accumulate.
// One accepted sample triggers NOF_COEFF MAC cycles over the delay line, then
// a registered, scaled and saturated/wrapped result is offered downstream.
module fir_mac_seq #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NOF_COEFF  = 12,
  parameter  int OUT_WIDTH  = 20,
  parameter  int SHIFT      = 0,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NOF_COEFF),
  localparam int ADDR_WIDTH = $clog2(NOF_COEFF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         sat_en,
  input  logic                         coeff_we,
  input  logic [ADDR_WIDTH-1:0]        coeff_addr,
  input  logic signed [DATA_WIDTH-1:0] coeff_data,
  output logic                         coeff_wr_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam int PROD_WIDTH = 2*DATA_WIDTH;
  // One extra bit over both the accumulator and the output so the range test
  // works whichever of the two is wider.
  localparam int WIDE_WIDTH = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

  localparam logic signed [WIDE_WIDTH-1:0] OUT_MAX =
    {{(WIDE_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  localparam logic [ADDR_WIDTH:0]   TAP_LIMIT = (ADDR_WIDTH+1)'(NOF_COEFF);
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP  = ADDR_WIDTH'(NOF_COEFF-1);

  logic [1:0]                   state;
  logic [ADDR_WIDTH-1:0]        tap;
  logic signed [DATA_WIDTH-1:0] x [NOF_COEFF];
  logic signed [DATA_WIDTH-1:0] h [NOF_COEFF];
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                         sample_accept;
  logic                         coeff_ok;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [WIDE_WIDTH-1:0] wide;
  logic signed [OUT_WIDTH-1:0]  fmt_data;
  logic                         fmt_sat;

  // in_ready is forced low while reset is asserted so every output reads 0.
  assign in_ready      = rst_n && (state == IDLE);
  assign sample_accept = in_valid && (state == IDLE);
  assign coeff_ok      = coeff_we && (state == IDLE) && ({1'b0, coeff_addr} < TAP_LIMIT);

  assign prod     = PROD_WIDTH'(x[tap]) * PROD_WIDTH'(h[tap]);
  assign acc_next = acc + ACC_WIDTH'(prod);

  // Scale the final sum and fit it into OUT_WIDTH, clipping or wrapping.
  always_comb begin
    shifted  = acc_next >>> SHIFT;
    wide     = WIDE_WIDTH'(shifted);
    fmt_data = wide[OUT_WIDTH-1:0];
    fmt_sat  = 1'b0;
    if (wide > OUT_MAX) begin
      fmt_sat = 1'b1;
      if (sat_en) fmt_data = OUT_MAX[OUT_WIDTH-1:0];
    end else if (wide < OUT_MIN) begin
      fmt_sat = 1'b1;
      if (sat_en) fmt_data = OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  // Coefficient file: writable only while idle, survives clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOF_COEFF; i++) h[i] <= '0;
    end else if (coeff_ok) begin
      h[coeff_addr] <= coeff_data;
    end
  end

  // Dropped coefficient writes are flagged one cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coeff_wr_err <= 1'b0;
    else        coeff_wr_err <= coeff_we && !coeff_ok;
  end

  // Sample delay line: shifts on acceptance, flushed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NOF_COEFF; i++) x[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NOF_COEFF; i++) x[i] <= '0;
    end else if (sample_accept) begin
      x[0] <= in_data;
      for (int i = 1; i < NOF_COEFF; i++) x[i] <= x[i-1];
    end
  end

  // Sequencer: accept, walk the taps, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_accept) begin
            state <= MAC;
            tap   <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (tap == LAST_TAP) begin
            out_data  <= fmt_data;
            out_sat   <= fmt_sat;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: three instances (default, 16-bit output, shift by 2)
// share one stimulus stream and are checked every cycle against a
// behavioural model, plus hand-computed directed expectations.
module tb_fir_mac_seq;

  localparam int N = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic sat_en = 1'b0;
  logic coeff_we = 1'b0;
  logic [3:0] coeff_addr = '0;
  logic signed [7:0] coeff_data = '0;
  logic in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic out_ready = 1'b0;

  logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, err_a, err_b, err_c, os_a, os_b, os_c;
  logic signed [19:0] od_a, od_c;
  logic signed [15:0] od_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Behavioural model state
  logic signed [7:0] mx [N];
  logic signed [7:0] mh [N];
  int     m_count = 0;
  bit     m_outv = 1'b0, m_err = 1'b0, m_idle = 1'b1, m_accept = 1'b0;
  longint m_acc = 0;
  longint e_a = 0, e_b = 0, e_c = 0;
  bit     es_a = 1'b0, es_b = 1'b0, es_c = 1'b0;

  always #5 clk = ~clk;

  fir_mac_seq dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sat_en(sat_en),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_wr_err(err_a),
    .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_sat(os_a));

  fir_mac_seq #(.OUT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sat_en(sat_en),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_wr_err(err_b),
    .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_sat(os_b));

  fir_mac_seq #(.SHIFT(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sat_en(sat_en),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_wr_err(err_c),
    .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_sat(os_c));

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Floor-shift, then clip or wrap to a signed w-bit field.
  function automatic void fmt(input longint acc, input int sh, input int w, input bit sat,
                              output longint d, output bit s);
    longint v, hi, lo, span;
    v    = acc >>> sh;
    span = longint'(1) <<< w;
    hi   = (longint'(1) <<< (w-1)) - 1;
    lo   = -(longint'(1) <<< (w-1));
    if (v <= hi && v >= lo) begin
      d = v; s = 1'b0;
    end else if (sat) begin
      d = (v > hi) ? hi : lo; s = 1'b1;
    end else begin
      d = v & (span - 1);
      if (d > hi) d = d - span;
      s = 1'b1;
    end
  endfunction

  // Reference model: a sample's result is the dot product of the delay line
  // and coefficients at acceptance, offered N edges later until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin mx[i] = '0; mh[i] = '0; end
      m_count = 0; m_outv = 1'b0; m_err = 1'b0; m_accept = 1'b0; m_acc = 0;
      m_idle = 1'b1;
    end else begin
      m_idle   = (m_count == 0) && !m_outv;
      m_accept = 1'b0;
      m_err    = coeff_we && !(m_idle && coeff_addr < N);
      if (coeff_we && m_idle && coeff_addr < N) mh[coeff_addr] = coeff_data;
      if (clear) begin
        for (int i = 0; i < N; i++) mx[i] = '0;
        m_count = 0; m_outv = 1'b0;
      end else if (m_idle) begin
        if (in_valid) begin
          for (int i = N-1; i > 0; i--) mx[i] = mx[i-1];
          mx[0] = in_data;
          m_acc = 0;
          for (int i = 0; i < N; i++) m_acc += longint'(mx[i]) * longint'(mh[i]);
          m_count  = N;
          m_accept = 1'b1;
        end
      end else if (m_count > 0) begin
        m_count--;
        if (m_count == 0) begin
          m_outv = 1'b1;
          fmt(m_acc, 0, 20, sat_en, e_a, es_a);
          fmt(m_acc, 0, 16, sat_en, e_b, es_b);
          fmt(m_acc, 2, 20, sat_en, e_c, es_c);
        end
      end else if (m_outv && out_ready) begin
        m_outv = 1'b0;
      end
      m_idle = (m_count == 0) && !m_outv;
    end
  end

  // Every cycle: compare all three instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      bit exp_rdy;
      exp_rdy = rst_n && (m_count == 0) && !m_outv;
      checkOutput("in_ready_a", rdy_a, exp_rdy);
      checkOutput("in_ready_b", rdy_b, exp_rdy);
      checkOutput("in_ready_c", rdy_c, exp_rdy);
      checkOutput("out_valid_a", ov_a, m_outv);
      checkOutput("out_valid_b", ov_b, m_outv);
      checkOutput("out_valid_c", ov_c, m_outv);
      checkOutput("coeff_wr_err_a", err_a, m_err);
      checkOutput("coeff_wr_err_b", err_b, m_err);
      checkOutput("coeff_wr_err_c", err_c, m_err);
      if (m_outv) begin
        checkOutput("out_data_a", longint'(od_a), e_a);
        checkOutput("out_data_b", longint'(od_b), e_b);
        checkOutput("out_data_c", longint'(od_c), e_c);
        checkOutput("out_sat_a", os_a, es_a);
        checkOutput("out_sat_b", os_b, es_b);
        checkOutput("out_sat_c", os_c, es_c);
      end
      if (!rst_n) begin
        checkOutput("reset out_data_a", longint'(od_a), 0);
        checkOutput("reset out_sat_a", os_a, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input int addr, input int data);
    coeff_we = 1'b1; coeff_addr = 4'(addr); coeff_data = 8'(data);
    tick();
    coeff_we = 1'b0;
  endtask

  task automatic push_sample(input logic signed [7:0] d);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d;
    while (!done && n < 100) begin
      done = rdy_a;
      tick();
      n++;
    end
    in_valid = 1'b0;
    checkOutput("push accepted", done, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ov_a && n < 100) begin tick(); n++; end
    checkOutput("out_valid arrived", ov_a, 1);
  endtask

  task automatic pop_result(output longint a, output longint b, output longint c,
                            output bit sa, output bit sb, output bit sc);
    int n = 0;
    bit got = 1'b0;
    a = 0; b = 0; c = 0; sa = 0; sb = 0; sc = 0;
    out_ready = 1'b1;
    while (!got && n < 100) begin
      if (ov_a) begin
        got = 1'b1;
        a = od_a; b = od_b; c = od_c; sa = os_a; sb = os_b; sc = os_c;
      end
      tick();
      n++;
    end
    out_ready = 1'b0;
    checkOutput("pop got result", got, 1);
  endtask

  // Impulse with h[k]=k+1: outputs walk 1..12; acceptance cycle counts as the
  // first, so out_valid appears N edges after the accepting edge.
  task automatic run_impulse();
    longint a, b, c;
    bit sa, sb, sc;
    for (int k = 0; k < N; k++) write_coeff(k, k + 1);
    for (int k = 0; k < N; k++) begin
      push_sample((k == 0) ? 8'sd1 : 8'sd0);
      if (k == 0) begin
        int n = 0;
        while (!ov_a && n < 40) begin tick(); n++; end
        checkOutput("impulse latency edges", n, N);
      end
      pop_result(a, b, c, sa, sb, sc);
      checkOutput("impulse out_data", a, k + 1);
      checkOutput("impulse out_sat", sa, 0);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (!(in_valid && !m_accept)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = 8'($urandom);
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      coeff_we   = ($urandom_range(0, 7) == 0);
      coeff_addr = 4'($urandom_range(0, 15));
      coeff_data = 8'($urandom);
      sat_en     = 1'($urandom);
      clear      = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 1'b0; coeff_we = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    longint a, b, c;
    bit sa, sb, sc;
    int n;
    $display("[TB] start");
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", ov_a, 0);
    checkOutput("reset in_ready", rdy_a, 0);
    checkOutput("reset out_data", longint'(od_a), 0);
    checkOutput("reset coeff_wr_err", err_a, 0);
    rst_n = 1'b1;
    tick();

    run_impulse();

    // Back-to-back throughput: accept-to-accept spacing is N+2 edges.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'sd0;
    n = 0;
    while (!rdy_a && n < 40) begin tick(); n++; end
    tick();
    n = 0;
    while (!rdy_a && n < 40) begin tick(); n++; end
    checkOutput("accept spacing edges", n + 1, N + 2);
    tick();
    in_valid = 1'b0;
    wait_valid();
    tick();
    out_ready = 1'b0;

    // Backpressure: delay line is all zero, so sample 2 gives 2*h[0] = 2.
    push_sample(8'sd2);
    wait_valid();
    in_valid = 1'b1; in_data = 8'sd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp out_data held", longint'(od_a), 2);
      checkOutput("bp out_valid held", ov_a, 1);
      checkOutput("bp in_ready low", rdy_a, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp ready in first idle", rdy_a, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("bp sample taken", rdy_a, 0);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("bp next out_data", a, 7 * 1 + 2 * 2);

    // Saturation: all h=-128, twelve -128 samples -> acc = 196608.
    sat_en = 1'b1;
    for (int k = 0; k < N; k++) write_coeff(k, -128);
    for (int k = 0; k < N; k++) begin
      push_sample(-8'sd128);
      pop_result(a, b, c, sa, sb, sc);
    end
    checkOutput("sat 20b out_data", a, 196608);
    checkOutput("sat 20b out_sat", sa, 0);
    checkOutput("sat 16b clip data", b, 32767);
    checkOutput("sat 16b clip flag", sb, 1);
    sat_en = 1'b0;
    push_sample(-8'sd128);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("wrap 16b data", b, 0);
    checkOutput("wrap 16b flag", sb, 1);

    // SHIFT: only h[0]=1, input -7 -> -7 >>> 2 = -2.
    write_coeff(0, 1);
    for (int k = 1; k < N; k++) write_coeff(k, 0);
    push_sample(-8'sd7);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("shift0 out_data", a, -7);
    checkOutput("shift2 out_data", c, -2);
    checkOutput("shift2 out_sat", sc, 0);

    // Coefficient write rules.
    push_sample(8'sd4);
    tick();
    coeff_we = 1'b1; coeff_addr = 4'd0; coeff_data = 8'sd99;
    tick();
    coeff_we = 1'b0;
    checkOutput("wr in MAC err", err_a, 1);
    tick();
    checkOutput("wr err one cycle", err_a, 0);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("h unchanged after MAC write", a, 4);
    coeff_we = 1'b1; coeff_addr = 4'd12; coeff_data = 8'sd1;
    tick();
    coeff_we = 1'b0;
    checkOutput("wr addr 12 err", err_a, 1);
    coeff_we = 1'b1; coeff_addr = 4'd0; coeff_data = 8'sd5;
    in_valid = 1'b1; in_data = 8'sd3;
    tick();
    coeff_we = 1'b0; in_valid = 1'b0;
    checkOutput("coincident accept", rdy_a, 0);
    checkOutput("coincident no err", err_a, 0);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("coincident write used", a, 15);

    // Reset mid-MAC.
    push_sample(8'sd9);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", ov_a, 0);
    checkOutput("midrst in_ready", rdy_a, 0);
    checkOutput("midrst out_data", longint'(od_a), 0);
    checkOutput("midrst out_sat", os_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    push_sample(8'sd5);
    pop_result(a, b, c, sa, sb, sc);
    checkOutput("post reset out_data", a, 0);

    // Clear in OUT discards the result but keeps coefficients.
    for (int k = 0; k < N; k++) write_coeff(k, k + 1);
    push_sample(8'sd1);
    wait_valid();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear drops out_valid", ov_a, 0);
    checkOutput("clear back to idle", rdy_a, 1);
    run_impulse();

    applyStimulus(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
